// File: rtl/axil_stream_ctrl_master_if.sv
// Bundle for axil_stream_ctrl_master: command stream in, response stream out, AXI-Lite initiator.
// master = the bridge's view, slave = the environment (host stream + register block).
interface axil_stream_ctrl_master_if #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 1
);
  logic [AXIS_BUS_WIDTH-1:0]   axis_in_tdata;
  logic [AXIS_ID_WIDTH-1:0]    axis_in_tdest;
  logic [AXIS_BUS_WIDTH/8-1:0] axis_in_tkeep;
  logic                        axis_in_tlast;
  logic                        axis_in_tvalid;
  logic                        axis_in_tready;

  logic [AXIS_BUS_WIDTH-1:0]   axis_out_tdata;
  logic [AXIS_ID_WIDTH-1:0]    axis_out_tid;
  logic [AXIS_ID_WIDTH-1:0]    axis_out_tdest;
  logic [AXIS_BUS_WIDTH/8-1:0] axis_out_tkeep;
  logic                        axis_out_tlast;
  logic                        axis_out_tvalid;
  logic                        axis_out_tready;

  logic [31:0] ctrl_awaddr;
  logic        ctrl_awvalid;
  logic        ctrl_awready;
  logic [31:0] ctrl_wdata;
  logic [3:0]  ctrl_wstrb;
  logic        ctrl_wvalid;
  logic        ctrl_wready;
  logic [1:0]  ctrl_bresp;
  logic        ctrl_bvalid;
  logic        ctrl_bready;
  logic [31:0] ctrl_araddr;
  logic        ctrl_arvalid;
  logic        ctrl_arready;
  logic [31:0] ctrl_rdata;
  logic [1:0]  ctrl_rresp;
  logic        ctrl_rvalid;
  logic        ctrl_rready;

  modport master (
    input  axis_in_tdata, axis_in_tdest, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
    output axis_in_tready,
    output axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
    input  axis_out_tready,
    output ctrl_awaddr, ctrl_awvalid, input ctrl_awready,
    output ctrl_wdata, ctrl_wstrb, ctrl_wvalid, input ctrl_wready,
    input  ctrl_bresp, ctrl_bvalid, output ctrl_bready,
    output ctrl_araddr, ctrl_arvalid, input ctrl_arready,
    input  ctrl_rdata, ctrl_rresp, ctrl_rvalid, output ctrl_rready
  );

  modport slave (
    output axis_in_tdata, axis_in_tdest, axis_in_tkeep, axis_in_tlast, axis_in_tvalid,
    input  axis_in_tready,
    input  axis_out_tdata, axis_out_tid, axis_out_tdest, axis_out_tkeep, axis_out_tlast, axis_out_tvalid,
    output axis_out_tready,
    input  ctrl_awaddr, ctrl_awvalid, output ctrl_awready,
    input  ctrl_wdata, ctrl_wstrb, ctrl_wvalid, output ctrl_wready,
    output ctrl_bresp, ctrl_bvalid, input ctrl_bready,
    input  ctrl_araddr, ctrl_arvalid, output ctrl_arready,
    output ctrl_rdata, ctrl_rresp, ctrl_rvalid, input ctrl_rready
  );
endinterface

// File: rtl/axil_stream_ctrl_master.sv
// AXI-Stream command packet -> one AXI-Lite transaction -> one response beat; one command in flight.
// Optional AXI-Lite wait bound: define AXIL_MASTER_TIMEOUT_EN (limit = TIMEOUT_CYCLES).
module axil_stream_ctrl_master #(
  parameter int AXIS_BUS_WIDTH = 64,
  parameter int AXIS_ID_WIDTH  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic aclk,
  input logic areset,
  axil_stream_ctrl_master_if.master bus
);
  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, RESP, DRAIN} state_t;
  localparam int PAD_W = AXIS_BUS_WIDTH - 36;

  state_t                   state;
  logic                     op_q;
  logic                     drain_q;
  logic [AXIS_ID_WIDTH-1:0] tdest_q;
  logic                     in_hs, aw_ok, w_ok, done;
  logic                     unused_bits;

  function automatic logic [AXIS_BUS_WIDTH-1:0] pack_resp(input logic op, input logic tmo,
                                                          input logic [1:0] resp, input logic [31:0] rd);
    return {{PAD_W{1'b0}}, op, tmo, resp, rd};
  endfunction

  // tready is gated by areset so it is low throughout reset yet high on the first cycle after.
  assign bus.axis_in_tready = ~areset & ((state == IDLE) | (state == DRAIN));
  assign in_hs              = bus.axis_in_tvalid & bus.axis_in_tready;
  assign bus.ctrl_bready    = (state == WRESP);
  assign bus.ctrl_rready    = (state == RDATA);
  assign bus.ctrl_wstrb     = 4'hF;
  assign bus.axis_out_tkeep = '1;
  assign bus.axis_out_tlast = 1'b1;
  assign bus.axis_out_tid   = '0;
  assign bus.axis_out_tdest = tdest_q;
  assign unused_bits        = ^{bus.axis_in_tkeep, bus.axis_in_tdata[62]};

  // aw and w complete independently; a channel whose valid already dropped counts as done.
  assign aw_ok = ~bus.ctrl_awvalid | bus.ctrl_awready;
  assign w_ok  = ~bus.ctrl_wvalid  | bus.ctrl_wready;

  always_comb begin
    done = 1'b0;
    case (state)
      WRITE:   done = aw_ok & w_ok;
      WRESP:   done = bus.ctrl_bvalid;
      READ:    done = bus.ctrl_arready;
      RDATA:   done = bus.ctrl_rvalid;
      default: done = 1'b0;
    endcase
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_busy, tmo_fire;
  assign tmo_busy = (state == WRITE) | (state == WRESP) | (state == READ) | (state == RDATA);
  // completion in the limit cycle wins over the timeout
  assign tmo_fire = tmo_busy & ~done & (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic tmo_cycles_unused;
  assign tmo_cycles_unused = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state               <= IDLE;
      op_q                <= 1'b0;
      drain_q             <= 1'b0;
      tdest_q             <= '0;
      bus.ctrl_awaddr     <= '0;
      bus.ctrl_awvalid    <= 1'b0;
      bus.ctrl_wdata      <= '0;
      bus.ctrl_wvalid     <= 1'b0;
      bus.ctrl_araddr     <= '0;
      bus.ctrl_arvalid    <= 1'b0;
      bus.axis_out_tdata  <= '0;
      bus.axis_out_tvalid <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
      tmo_cnt             <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_hs) begin
          op_q    <= bus.axis_in_tdata[63];
          tdest_q <= bus.axis_in_tdest;
          drain_q <= ~bus.axis_in_tlast;
          if (bus.axis_in_tdata[63]) begin
            bus.ctrl_awaddr  <= {bus.axis_in_tdata[61:32], 2'b00};
            bus.ctrl_wdata   <= bus.axis_in_tdata[31:0];
            bus.ctrl_awvalid <= 1'b1;
            bus.ctrl_wvalid  <= 1'b1;
            state            <= WRITE;
          end else begin
            bus.ctrl_araddr  <= {bus.axis_in_tdata[61:32], 2'b00};
            bus.ctrl_arvalid <= 1'b1;
            state            <= READ;
          end
        end
        WRITE: begin
          if (bus.ctrl_awready) bus.ctrl_awvalid <= 1'b0;
          if (bus.ctrl_wready)  bus.ctrl_wvalid  <= 1'b0;
          if (done)             state            <= WRESP;
        end
        WRESP: if (bus.ctrl_bvalid) begin
          bus.axis_out_tdata  <= pack_resp(1'b1, 1'b0, bus.ctrl_bresp, 32'h0);
          bus.axis_out_tvalid <= 1'b1;
          state               <= RESP;
        end
        READ: if (bus.ctrl_arready) begin
          bus.ctrl_arvalid <= 1'b0;
          state            <= RDATA;
        end
        RDATA: if (bus.ctrl_rvalid) begin
          bus.axis_out_tdata  <= pack_resp(1'b0, 1'b0, bus.ctrl_rresp, bus.ctrl_rdata);
          bus.axis_out_tvalid <= 1'b1;
          state               <= RESP;
        end
        RESP: if (bus.axis_out_tready) begin
          bus.axis_out_tvalid <= 1'b0;
          state               <= drain_q ? DRAIN : IDLE;
        end
        DRAIN: if (in_hs && bus.axis_in_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
`ifdef AXIL_MASTER_TIMEOUT_EN
      if (state == IDLE)  tmo_cnt <= '0;
      else if (tmo_busy)  tmo_cnt <= tmo_cnt + 1'b1;
      // abandon the transaction: drop every AXI valid and report SLVERR with the timeout flag
      if (tmo_fire) begin
        bus.ctrl_awvalid    <= 1'b0;
        bus.ctrl_wvalid     <= 1'b0;
        bus.ctrl_arvalid    <= 1'b0;
        bus.axis_out_tdata  <= pack_resp(op_q, 1'b1, 2'b10, 32'h0);
        bus.axis_out_tvalid <= 1'b1;
        state               <= RESP;
      end
`endif
    end
  end
endmodule

// File: tb/tb_axil_stream_ctrl_master.sv
// Scoreboard bench for axil_stream_ctrl_master: expected responses queued at command issue, popped on output.
module tb_axil_stream_ctrl_master;
  typedef struct {
    logic [63:0] data;
    logic        dest;
  } exp_t;

  logic aclk, areset;
  axil_stream_ctrl_master_if #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(1)) bus();

  axil_stream_ctrl_master #(.AXIS_BUS_WIDTH(64), .AXIS_ID_WIDTH(1), .TIMEOUT_CYCLES(16)) dut (
    .aclk(aclk), .areset(areset), .bus(bus.master)
  );

  exp_t        exp_q[$];
  int          n_chk, n_fail, cyc, t_acc;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, out_cnt;
  logic [31:0] aw_seen, w_seen, ar_seen, slv_rdata;
  logic [3:0]  wstrb_seen;
  logic [1:0]  slv_bresp, slv_rresp;
  bit          aw_fire, w_fire, ar_fire, b_fire, r_fire;
  bit          got_aw, got_w, got_ar, hold_prev;
  logic [63:0] hold_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [63:0] cmd, input logic dest);
    exp_t e;
    e.data = {28'h0, cmd[63], 1'b0, cmd[63] ? slv_bresp : slv_rresp, cmd[63] ? 32'h0 : slv_rdata};
    e.dest = dest;
    return e;
  endfunction

  initial begin aclk = 0; forever #5 aclk = ~aclk; end
  initial forever begin @(posedge aclk); cyc++; end

  // monitor: count handshakes, check held responses and score every output beat
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      aw_fire = !areset && bus.ctrl_awvalid && bus.ctrl_awready;
      w_fire  = !areset && bus.ctrl_wvalid && bus.ctrl_wready;
      ar_fire = !areset && bus.ctrl_arvalid && bus.ctrl_arready;
      b_fire  = !areset && bus.ctrl_bvalid && bus.ctrl_bready;
      r_fire  = !areset && bus.ctrl_rvalid && bus.ctrl_rready;
      if (areset) hold_prev = 0;
      else begin
        if (aw_fire) begin aw_cnt++; aw_seen = bus.ctrl_awaddr; end
        if (w_fire) begin w_cnt++; w_seen = bus.ctrl_wdata; wstrb_seen = bus.ctrl_wstrb; end
        if (ar_fire) begin ar_cnt++; ar_seen = bus.ctrl_araddr; end
        if (b_fire) b_cnt++;
        if (r_fire) r_cnt++;
        if (hold_prev && bus.axis_out_tvalid) chk("hold_stable", bus.axis_out_tdata, hold_data);
        if (bus.axis_out_tvalid && bus.axis_out_tready) begin
          out_cnt++;
          if (exp_q.size() == 0) chk("unexpected_resp", bus.axis_out_tdata, 64'hX);
          else begin
            e = exp_q.pop_front();
            chk("resp_tdata", bus.axis_out_tdata, e.data);
            chk("resp_tdest", 64'(bus.axis_out_tdest), 64'(e.dest));
            chk("resp_last_keep_id", {bus.axis_out_tlast, bus.axis_out_tkeep, bus.axis_out_tid},
                {1'b1, 8'hFF, 1'b0});
          end
        end
        hold_prev = bus.axis_out_tvalid && !bus.axis_out_tready;
        hold_data = bus.axis_out_tdata;
      end
    end
  end

  // AXI-Lite slave: b one cycle after both aw and w, r one cycle after ar
  initial begin
    bus.ctrl_bvalid = 0; bus.ctrl_bresp = 0;
    bus.ctrl_rvalid = 0; bus.ctrl_rresp = 0; bus.ctrl_rdata = 0;
    forever begin
      @(posedge aclk); #1;
      if (areset) begin
        bus.ctrl_bvalid = 0; bus.ctrl_rvalid = 0;
        got_aw = 0; got_w = 0; got_ar = 0;
      end else begin
        if (aw_fire) got_aw = 1;
        if (w_fire)  got_w  = 1;
        if (ar_fire) got_ar = 1;
        if (b_fire) begin bus.ctrl_bvalid = 0; got_aw = 0; got_w = 0; end
        else if (got_aw && got_w && !bus.ctrl_bvalid) begin
          bus.ctrl_bvalid = 1; bus.ctrl_bresp = slv_bresp;
        end
        if (r_fire) begin bus.ctrl_rvalid = 0; got_ar = 0; end
        else if (got_ar && !bus.ctrl_rvalid) begin
          bus.ctrl_rvalid = 1; bus.ctrl_rdata = slv_rdata; bus.ctrl_rresp = slv_rresp;
        end
      end
    end
  end

  task automatic send_beat(input logic [63:0] d, input logic dst, input logic last);
    bit ok;
    ok = 0;
    bus.axis_in_tdata = d; bus.axis_in_tdest = dst; bus.axis_in_tlast = last;
    bus.axis_in_tkeep = 8'hFF; bus.axis_in_tvalid = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (bus.axis_in_tready) begin ok = 1; t_acc = cyc; break; end
    end
    @(posedge aclk); #1;
    bus.axis_in_tvalid = 0;
    if (!ok) chk("in_accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      chk("resp_missing", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(posedge aclk); #1;
  endtask

  task automatic wait_tvalid(output int lat);
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (bus.axis_out_tvalid) begin lat = cyc - t_acc; break; end
    end
    if (lat < 0) chk("tvalid_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    int lat, a0, w0, b0, o0, n;
    logic [63:0] cmd;
    areset = 1;
    bus.axis_in_tvalid = 0; bus.axis_in_tdata = 0; bus.axis_in_tdest = 0;
    bus.axis_in_tkeep = 0; bus.axis_in_tlast = 0; bus.axis_out_tready = 1;
    bus.ctrl_awready = 1; bus.ctrl_wready = 1; bus.ctrl_arready = 1;
    slv_rdata = 0; slv_rresp = 0; slv_bresp = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_valids_readys", {bus.ctrl_awvalid, bus.ctrl_wvalid, bus.ctrl_arvalid, bus.ctrl_bready,
        bus.ctrl_rready, bus.axis_out_tvalid, bus.axis_in_tready}, 64'd0);
    chk("rst_addrs", {bus.ctrl_awaddr, bus.ctrl_araddr}, 64'd0);
    chk("rst_wdata", 64'(bus.ctrl_wdata), 64'd0);
    chk("rst_tdata", bus.axis_out_tdata, 64'd0);
    @(posedge aclk); #1;
    areset = 0;
    @(negedge aclk);
    chk("rst_release_tready", 64'(bus.axis_in_tready), 64'd1);
    @(posedge aclk); #1;

    // write
    cmd = 64'h8000_0001_DEAD_BEEF;
    exp_q.push_back(model(cmd, 1'b1));
    send_beat(cmd, 1'b1, 1'b1);
    wait_resp();
    chk("wr_awaddr", 64'(aw_seen), 64'h4);
    chk("wr_wdata", 64'(w_seen), 64'hDEAD_BEEF);
    chk("wr_wstrb", 64'(wstrb_seen), 64'hF);
    chk("wr_counts", {32'(aw_cnt), 16'(w_cnt), 16'(b_cnt)}, {32'd1, 16'd1, 16'd1});

    // read, zero-wait latency
    slv_rdata = 32'h1234_5678;
    cmd = 64'h0000_0002_0000_0000;
    exp_q.push_back(model(cmd, 1'b0));
    send_beat(cmd, 1'b0, 1'b1);
    wait_tvalid(lat);
    chk("rd_latency", 64'(lat), 64'd3);
    wait_resp();
    chk("rd_araddr", 64'(ar_seen), 64'h8);

    // independent aw/w: awready five cycles behind wready
    slv_bresp = 2'b10;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    bus.ctrl_awready = 0;
    cmd = 64'h8000_0010_0000_00A5;
    exp_q.push_back(model(cmd, 1'b0));
    send_beat(cmd, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      chk("aw_held", 64'(bus.ctrl_awvalid), 64'd1);
      if (i > 0) chk("w_dropped", 64'(bus.ctrl_wvalid), 64'd0);
      @(posedge aclk); #1;
    end
    bus.ctrl_awready = 1;
    wait_resp();
    chk("ind_counts", {32'(aw_cnt - a0), 16'(w_cnt - w0), 16'(b_cnt - b0)}, {32'd1, 16'd1, 16'd1});
    chk("ind_awaddr", 64'(aw_seen), 64'h40);
    slv_bresp = 2'b00;

    // multi-beat command: trailing beats are drained silently
    slv_rdata = 32'h0BAD_F00D;
    a0 = ar_cnt; w0 = aw_cnt; o0 = out_cnt;
    cmd = 64'h0000_0003_0000_0000;
    exp_q.push_back(model(cmd, 1'b1));
    send_beat(cmd, 1'b1, 1'b0);
    send_beat(64'h8000_0009_1111_1111, 1'b1, 1'b0);
    send_beat(64'h8000_000A_2222_2222, 1'b1, 1'b1);
    wait_resp();
    chk("mb_ar_count", 64'(ar_cnt - a0), 64'd1);
    chk("mb_aw_count", 64'(aw_cnt - w0), 64'd0);
    chk("mb_resp_count", 64'(out_cnt - o0), 64'd1);
    chk("mb_araddr", 64'(ar_seen), 64'hC);

    // next command right after the drain must be processed normally
    slv_rdata = 32'hCAFE_0001; slv_rresp = 2'b01;
    cmd = 64'h0000_0100_0000_0000;
    exp_q.push_back(model(cmd, 1'b1));
    send_beat(cmd, 1'b1, 1'b1);
    wait_resp();
    chk("post_drain_araddr", 64'(ar_seen), 64'h400);
    slv_rresp = 2'b00;

    // backpressure: response held for 10 cycles, no new command taken
    bus.axis_out_tready = 0;
    cmd = 64'h8000_0005_0000_0001;
    exp_q.push_back(model(cmd, 1'b0));
    send_beat(cmd, 1'b0, 1'b1);
    wait_tvalid(lat);
    for (int i = 0; i < 10; i++) begin
      @(posedge aclk); #1;
      @(negedge aclk);
      chk("bp_tvalid", 64'(bus.axis_out_tvalid), 64'd1);
      chk("bp_no_accept", 64'(bus.axis_in_tready), 64'd0);
    end
    @(posedge aclk); #1;
    bus.axis_out_tready = 1;
    wait_resp();

    // reset while a response is held: it must vanish
    bus.axis_out_tready = 0;
    o0 = out_cnt;
    send_beat(64'h0000_0004_0000_0000, 1'b0, 1'b1);
    wait_tvalid(lat);
    @(posedge aclk); #1;
    areset = 1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_resp_tvalid", 64'(bus.axis_out_tvalid), 64'd0);
    bus.axis_out_tready = 1;
    @(posedge aclk); #1;
    areset = 0;
    repeat (6) @(posedge aclk);
    #1;
    chk("rst_no_resp", 64'(out_cnt - o0), 64'd0);

    // reset while arvalid is waiting on arready
    bus.ctrl_arready = 0;
    send_beat(64'h0000_0006_0000_0000, 1'b0, 1'b1);
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("ar_pending", 64'(bus.ctrl_arvalid), 64'd1);
    @(posedge aclk); #1;
    areset = 1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("rst_ar_dropped", {bus.ctrl_arvalid, bus.ctrl_rready, bus.axis_out_tvalid}, 64'd0);
    bus.ctrl_arready = 1;
    @(posedge aclk); #1;
    areset = 0;
    @(posedge aclk); #1;

`ifdef AXIL_MASTER_TIMEOUT_EN
    bus.ctrl_arready = 0;
    exp_q.push_back('{data: 64'h0000_0006_0000_0000, dest: 1'b0});
    send_beat(64'h0000_0007_0000_0000, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (!bus.ctrl_arvalid) break;
      n++;
    end
    chk("tmo_arvalid_cycles", 64'(n), 64'd16);
    wait_resp();
    bus.ctrl_arready = 1;
`else
    n = 0;
`endif

    // recovery after resets
    o0 = out_cnt;
    cmd = 64'h8000_0020_0000_0077;
    exp_q.push_back(model(cmd, 1'b0));
    send_beat(cmd, 1'b0, 1'b1);
    wait_resp();
    chk("recover_awaddr", 64'(aw_seen), 64'h80);
    chk("recover_wdata", 64'(w_seen), 64'h77);
    chk("recover_resp_count", 64'(out_cnt - o0), 64'd1 + 64'(n * 0));

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
